// File: rtl/dcpu16_pkg.sv
// Shared types and constants for the dcpu16 memory bus arbiter.
package dcpu16_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFs   = 2'd1,
    StAb   = 2'd2
  } mbus_state_e;

  localparam int unsigned MbusTmoDefault = 255;

endpackage

// File: rtl/dcpu16_mbus_if.sv
// Bus bundle between the two CPU masters, the arbiter and the external memory port.
// slave: the arbiter's view; master: the CPU/memory environment around it.
interface dcpu16_mbus_if;
  import dcpu16_pkg::*;

  word_t fs_adr;
  logic  fs_stb;
  logic  fs_wre;
  word_t fs_dto;
  word_t fs_dti;
  logic  fs_ack;

  word_t ab_adr;
  logic  ab_stb;
  logic  ab_wre;
  word_t ab_dto;
  word_t ab_dti;
  logic  ab_ack;

  word_t wb_adr_o;
  word_t wb_dat_o;
  word_t wb_dat_i;
  logic  wb_cyc_o;
  logic  wb_stb_o;
  logic  wb_we_o;
  logic  wb_ack_i;

  logic  ena;
  logic  err;

  modport slave (
    input  fs_adr, fs_stb, fs_wre, fs_dto,
    output fs_dti, fs_ack,
    input  ab_adr, ab_stb, ab_wre, ab_dto,
    output ab_dti, ab_ack,
    output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i,
    output ena, err
  );

  modport master (
    output fs_adr, fs_stb, fs_wre, fs_dto,
    input  fs_dti, fs_ack,
    output ab_adr, ab_stb, ab_wre, ab_dto,
    input  ab_dti, ab_ack,
    input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i,
    input  ena, err
  );

endinterface

// File: rtl/dcpu16_mbus_port.sv
// Per-master response side: done flag, held read data, one-cycle ack and pending term.
module dcpu16_mbus_port
  import dcpu16_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  stb_i,
  input  logic  ena_i,
  input  logic  cmpl_i,
  input  logic  wr_i,
  input  word_t rdata_i,
  output word_t dti_o,
  output logic  ack_o,
  output logic  pend_o
);

  logic  done_q, done_d;
  logic  ack_q, ack_d;
  word_t dti_q, dti_d;

  always_comb begin
    done_d = done_q;
    dti_d  = dti_q;
    ack_d  = cmpl_i;
    // Completion only happens outside IDLE and ena only inside it, so these never collide.
    if (ena_i) done_d = 1'b0;
    if (cmpl_i) begin
      done_d = 1'b1;
      if (!wr_i) dti_d = rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      dti_q  <= '0;
    end else begin
      done_q <= done_d;
      ack_q  <= ack_d;
      dti_q  <= dti_d;
    end
  end

  assign dti_o  = dti_q;
  assign ack_o  = ack_q;
  assign pend_o = stb_i & ~done_q;

endmodule

// File: rtl/dcpu16_mbus.sv
// Fixed-priority arbiter of the FS and AB masters onto one memory port, with pipeline enable.
// Optional watchdog enabled by defining DCPU16_MBUS_TIMEOUT_EN.
module dcpu16_mbus
  import dcpu16_pkg::*;
#(
  parameter int unsigned TMO = MbusTmoDefault
) (
  input logic          clk,
  input logic          rst,
  dcpu16_mbus_if.slave bus
);

  mbus_state_e state_q, state_d;

  logic  pend_fs, pend_ab, ena;
  logic  busy, mem_done, tmo_hit;
  logic  grant_fs, grant_ab, cmpl_fs, cmpl_ab;
  word_t rdata;

  word_t adr_q, adr_d;
  word_t dat_q, dat_d;
  logic  we_q, we_d;
  logic  cyc_q, cyc_d;

  assign busy     = (state_q != StIdle);
  assign mem_done = busy & (bus.wb_ack_i | tmo_hit);
  assign ena      = (state_q == StIdle) & ~pend_fs & ~pend_ab;
  // A watchdog completion without ack returns zero as read data.
  assign rdata    = bus.wb_ack_i ? bus.wb_dat_i : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pend_fs)      state_d = StFs;
        else if (pend_ab) state_d = StAb;
      end
      StFs, StAb: begin
        if (mem_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_fs = (state_q == StIdle) & pend_fs;
    grant_ab = (state_q == StIdle) & ~pend_fs & pend_ab;
    cmpl_fs  = (state_q == StFs) & mem_done;
    cmpl_ab  = (state_q == StAb) & mem_done;

    adr_d = adr_q;
    dat_d = dat_q;
    we_d  = we_q;
    cyc_d = cyc_q;
    if (grant_fs) begin
      adr_d = bus.fs_adr;
      dat_d = bus.fs_dto;
      we_d  = bus.fs_wre;
      cyc_d = 1'b1;
    end else if (grant_ab) begin
      adr_d = bus.ab_adr;
      dat_d = bus.ab_dto;
      we_d  = bus.ab_wre;
      cyc_d = 1'b1;
    end else if (mem_done) begin
      cyc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      adr_q <= adr_d;
      dat_q <= dat_d;
      we_q  <= we_d;
      cyc_q <= cyc_d;
    end
  end

`ifdef DCPU16_MBUS_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;

  // Counter is 0 in the first strobe cycle, so the strobe is held for TMO cycles.
  assign tmo_hit = busy & (tmo_cnt_q == TmoW'(TMO - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (grant_fs | grant_ab) tmo_cnt_d = '0;
    else if (busy)           tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    if (tmo_hit & ~bus.wb_ack_i) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign tmo_hit    = 1'b0;
  assign bus.err    = 1'b0;
`endif

  dcpu16_mbus_port u_port_fs (
    .clk_i   (clk),
    .rst_i   (rst),
    .stb_i   (bus.fs_stb),
    .ena_i   (ena),
    .cmpl_i  (cmpl_fs),
    .wr_i    (we_q),
    .rdata_i (rdata),
    .dti_o   (bus.fs_dti),
    .ack_o   (bus.fs_ack),
    .pend_o  (pend_fs)
  );

  dcpu16_mbus_port u_port_ab (
    .clk_i   (clk),
    .rst_i   (rst),
    .stb_i   (bus.ab_stb),
    .ena_i   (ena),
    .cmpl_i  (cmpl_ab),
    .wr_i    (we_q),
    .rdata_i (rdata),
    .dti_o   (bus.ab_dti),
    .ack_o   (bus.ab_ack),
    .pend_o  (pend_ab)
  );

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.ena      = ena;

endmodule

// File: tb/tb_dcpu16_mbus.sv
// Directed, table-driven bench for dcpu16_mbus with a wait-state memory model.
module tb_dcpu16_mbus;
  import dcpu16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcpu16_mbus_if bus ();

  dcpu16_mbus #(.TMO(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: acks after mem_wait wait states; force_ack injects a stray ack.
  logic mem_en    = 1'b1;
  logic force_ack = 1'b0;
  int   mem_wait  = 0;
  int   wcnt      = 0;

  function automatic word_t mem_word(input word_t adr);
    return (adr == 16'h0010) ? 16'h7C01 : ~adr;
  endfunction

  always_ff @(posedge clk) begin
    if (!bus.wb_stb_o || bus.wb_ack_i) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  always_comb begin
    bus.wb_ack_i = force_ack | (mem_en & bus.wb_stb_o & (wcnt == mem_wait));
    bus.wb_dat_i = mem_word(bus.wb_adr_o);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic  fs_stb;
    logic  fs_wre;
    word_t fs_adr;
    word_t fs_dto;
    logic  ab_stb;
    logic  ab_wre;
    word_t ab_adr;
    word_t ab_dto;
    int    wait_st;
    int    fs_ack_at;
    int    ab_ack_at;
    int    ena_at;
    int    stb_cycles;
    int    we_cycles;
    word_t adr1;
    word_t dat1;
    logic  we1;
    word_t fs_dti;
    word_t ab_dti;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_idle();
    bus.fs_stb = 1'b0; bus.fs_wre = 1'b0; bus.fs_adr = '0; bus.fs_dto = '0;
    bus.ab_stb = 1'b0; bus.ab_wre = 1'b0; bus.ab_adr = '0; bus.ab_dto = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int fs_first = -1, ab_first = -1, ena_first = -1;
    int fs_cnt = 0, ab_cnt = 0, stb_cnt = 0, we_cnt = 0;
    int adr1 = -1, dat1 = -1, we1 = -1;
    mem_wait = v.wait_st;
    @(negedge clk);
    bus.fs_stb = v.fs_stb; bus.fs_wre = v.fs_wre; bus.fs_adr = v.fs_adr; bus.fs_dto = v.fs_dto;
    bus.ab_stb = v.ab_stb; bus.ab_wre = v.ab_wre; bus.ab_adr = v.ab_adr; bus.ab_dto = v.ab_dto;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.fs_ack) begin fs_cnt++; if (fs_first < 0) fs_first = c; end
      if (bus.ab_ack) begin ab_cnt++; if (ab_first < 0) ab_first = c; end
      if (bus.wb_stb_o) stb_cnt++;
      if (bus.wb_stb_o && bus.wb_we_o) we_cnt++;
      if (c == 1) begin
        adr1 = int'(bus.wb_adr_o); dat1 = int'(bus.wb_dat_o); we1 = int'(bus.wb_we_o);
      end
      if (bus.ena && ena_first < 0) begin
        ena_first = c;
        drive_idle();
      end
    end
    drive_idle();
    check($sformatf("v%0d_fs_ack_at", idx), fs_first, v.fs_ack_at);
    check($sformatf("v%0d_ab_ack_at", idx), ab_first, v.ab_ack_at);
    check($sformatf("v%0d_fs_ack_cnt", idx), fs_cnt, (v.fs_ack_at >= 0) ? 1 : 0);
    check($sformatf("v%0d_ab_ack_cnt", idx), ab_cnt, (v.ab_ack_at >= 0) ? 1 : 0);
    check($sformatf("v%0d_ena_at", idx), ena_first, v.ena_at);
    check($sformatf("v%0d_stb_cycles", idx), stb_cnt, v.stb_cycles);
    check($sformatf("v%0d_we_cycles", idx), we_cnt, v.we_cycles);
    check($sformatf("v%0d_adr1", idx), adr1, int'(v.adr1));
    check($sformatf("v%0d_dat1", idx), dat1, int'(v.dat1));
    check($sformatf("v%0d_we1", idx), we1, int'(v.we1));
    check($sformatf("v%0d_fs_dti", idx), int'(bus.fs_dti), int'(v.fs_dti));
    check($sformatf("v%0d_ab_dti", idx), int'(bus.ab_dti), int'(v.ab_dti));
  endtask

  initial begin
    int stb_cnt, ack_cnt, ena_cnt, ena_first, ack_first;

    //          fs: stb wre adr      dto      ab: stb wre adr      dto      wt fsA abA ena stb we
    //          adr1     dat1     we  fs_dti   ab_dti
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 2, -1, 2, 1, 0,
                16'h0010, 16'h0000, 1'b0, 16'h7C01, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 3, -1, 5, 5, 4, 4,
                16'h8000, 16'hBEEF, 1'b1, 16'h7C01, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0001, 16'h1111, 1'b1, 1'b0, 16'h0002, 16'h2222, 0, 2, 4, 4, 2, 0,
                16'h0001, 16'h1111, 1'b0, 16'hFFFE, 16'hFFFD};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 1, -1, 3, 3, 2, 0,
                16'h0003, 16'h0000, 1'b0, 16'hFFFE, 16'hFFFC};
    vecs[4] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0004, 16'h0000, 0, 2, 4, 4, 2, 1,
                16'h0020, 16'h1234, 1'b1, 16'hFFFE, 16'hFFFB};
    vecs[5] = '{1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b1, 1'b1, 16'h0040, 16'h5555, 2, 4, 8, 8, 6, 6,
                16'h0030, 16'hAAAA, 1'b1, 16'hFFFE, 16'hFFFB};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_adr", int'(bus.wb_adr_o), 0);
    check("rst_wb_dat", int'(bus.wb_dat_o), 0);
    check("rst_wb_cyc", int'(bus.wb_cyc_o), 0);
    check("rst_wb_stb", int'(bus.wb_stb_o), 0);
    check("rst_wb_we", int'(bus.wb_we_o), 0);
    check("rst_fs_dti", int'(bus.fs_dti), 0);
    check("rst_ab_dti", int'(bus.ab_dti), 0);
    check("rst_fs_ack", int'(bus.fs_ack), 0);
    check("rst_ab_ack", int'(bus.ab_ack), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_ena", int'(bus.ena), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    check("idle_ack_fs_ack", int'(bus.fs_ack), 0);
    check("idle_ack_ab_ack", int'(bus.ab_ack), 0);
    check("idle_ack_fs_dti", int'(bus.fs_dti), 16'hFFFE);
    check("idle_ack_ena", int'(bus.ena), 1);

    // Strobe held across ena edges: one memory cycle per ena period.
    mem_wait = 0;
    stb_cnt = 0; ack_cnt = 0; ena_cnt = 0;
    @(negedge clk);
    bus.fs_stb = 1'b1; bus.fs_adr = 16'h0010;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.wb_stb_o) stb_cnt++;
      if (bus.fs_ack) ack_cnt++;
      if (bus.ena) ena_cnt++;
    end
    drive_idle();
    check("held_stb_cycles", stb_cnt, 3);
    check("held_fs_acks", ack_cnt, 3);
    check("held_ena_cycles", ena_cnt, 3);

`ifdef DCPU16_MBUS_TIMEOUT_EN
    // Memory never answers: watchdog completes with zero data and sets err.
    mem_en = 1'b0;
    stb_cnt = 0; ack_first = -1; ena_first = -1;
    @(negedge clk);
    bus.fs_stb = 1'b1; bus.fs_adr = 16'h0060;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.wb_stb_o) stb_cnt++;
      if (bus.fs_ack && ack_first < 0) ack_first = c;
      if (bus.ena && ena_first < 0) begin
        ena_first = c;
        drive_idle();
      end
    end
    drive_idle();
    check("tmo_stb_cycles", stb_cnt, 4);
    check("tmo_fs_ack_at", ack_first, 5);
    check("tmo_ena_at", ena_first, 5);
    check("tmo_fs_dti", int'(bus.fs_dti), 0);
    check("tmo_err", int'(bus.err), 1);
    repeat (3) @(negedge clk);
    #1;
    check("tmo_err_sticky", int'(bus.err), 1);
    mem_en = 1'b1;
`else
    check("no_tmo_err", int'(bus.err), 0);
`endif

    // Reset in the middle of an FS access; a late ack must be ignored.
    mem_en = 1'b0;
    @(negedge clk);
    bus.fs_stb = 1'b1; bus.fs_adr = 16'h0050;
    #1;
    check("rstmid_ena0", int'(bus.ena), 0);
    @(negedge clk);
    #1;
    check("rstmid_stb_before", int'(bus.wb_stb_o), 1);
    rst = 1'b1;
    bus.fs_stb = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_cyc_after", int'(bus.wb_cyc_o), 0);
    check("rstmid_stb_after", int'(bus.wb_stb_o), 0);
    rst = 1'b0;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    check("rstmid_fs_ack", int'(bus.fs_ack), 0);
    check("rstmid_fs_dti", int'(bus.fs_dti), 0);
    check("rstmid_err", int'(bus.err), 0);
    check("rstmid_ena", int'(bus.ena), 1);
    mem_en = 1'b1;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
